// File: rtl/addsub_acc_seq_8bit.sv
// -----------------------------------------------------------------------------
// addsub_acc_seq_8bit
//
// Command sequencer and accumulator wrapped around an external, purely
// combinational 8-bit ripple-carry adder/subtractor. Commands (ADD, SUB,
// LOAD, CLEAR) are buffered in a DEPTH-entry FIFO. A two-state FSM pops one
// command into the issue registers (driving the adder's B and Add_ctrl),
// then on the following edge captures the adder result into the accumulator
// together with carry/zero/negative/overflow flags and pulses res_valid.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  FIFO not full
//   cmd_op     in   2  00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
//   cmd_data   in   8  operand / load value
//   A          out  8  adder A operand (accumulator)
//   B          out  8  adder B operand (issue-register data)
//   Add_ctrl   out  1  adder mode, 1 = subtract
//   SUM        in   8  adder sum
//   C_out      in   1  adder carry out (for SUB: 1 = no borrow)
//   acc        out  8  accumulator
//   flag_c/z/n/v out 1 carry, zero, negative, signed overflow
//   res_valid  out  1  one-cycle pulse after each accumulator update
//
// Build option:
//   ADDSUB_SAT_EN  when defined, ADD/SUB results saturate (unsigned) at
//                  0xFF / 0x00; flag_c and flag_v still describe the raw
//                  adder result. Undefined: modulo-256 wrap-around.
// -----------------------------------------------------------------------------
module addsub_acc_seq_8bit #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       Add_ctrl,
    input  logic [7:0] SUM,
    input  logic       C_out,
    output logic [7:0] acc,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_n,
    output logic       flag_v,
    output logic       res_valid
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_SUB   = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    // Signed overflow of a +/- b = s. For subtraction the adder computes
    // a + ~b + 1, so overflow needs operands of differing sign.
    function automatic logic ovf_calc(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] s, input logic sub);
        logic same_sign;
        same_sign = (a[7] == b[7]);
        return (sub ? !same_sign : same_sign) && (s[7] != a[7]);
    endfunction

    // FIFO storage and bookkeeping
    logic [9:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;

    // FSM, issue registers and result registers
    state_t     state_r;
    logic [1:0] issue_op_r;
    logic [7:0] b_r;
    logic       add_ctrl_r;
    logic [7:0] acc_r;
    logic       flag_c_r;
    logic       flag_z_r;
    logic       flag_n_r;
    logic       flag_v_r;
    logic       res_valid_r;

    logic       push_s;
    logic       pop_s;
    logic [9:0] head_s;
    logic [7:0] res_acc_s;
    logic       res_c_s;
    logic       res_v_s;

    assign cmd_ready = (count_r != DEPTH_C);
    assign head_s    = mem_r[rd_ptr_r];

    assign A         = acc_r;
    assign B         = b_r;
    assign Add_ctrl  = add_ctrl_r;
    assign acc       = acc_r;
    assign flag_c    = flag_c_r;
    assign flag_z    = flag_z_r;
    assign flag_n    = flag_n_r;
    assign flag_v    = flag_v_r;
    assign res_valid = res_valid_r;

    // FIFO handshake: accept when not full, pop only from IDLE when non-empty
    always_comb begin
        push_s = cmd_valid && cmd_ready;
        pop_s  = (state_r == ST_IDLE) && (count_r != '0);
    end

    // FIFO storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 10'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {cmd_op, cmd_data};
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Next accumulator value and raw-result flags for the op held in the issue registers
    always_comb begin
        res_acc_s = acc_r;
        res_c_s   = 1'b0;
        res_v_s   = 1'b0;
        case (issue_op_r)
            OP_ADD: begin
                res_c_s = C_out;
                res_v_s = ovf_calc(acc_r, b_r, SUM, 1'b0);
`ifdef ADDSUB_SAT_EN
                if (C_out) begin
                    res_acc_s = 8'hFF;
                end else begin
                    res_acc_s = SUM;
                end
`else
                res_acc_s = SUM;
`endif
            end
            OP_SUB: begin
                res_c_s = C_out;
                res_v_s = ovf_calc(acc_r, b_r, SUM, 1'b1);
`ifdef ADDSUB_SAT_EN
                // Borrow (C_out=0) means the true result is negative
                if (!C_out) begin
                    res_acc_s = 8'h00;
                end else begin
                    res_acc_s = SUM;
                end
`else
                res_acc_s = SUM;
`endif
            end
            OP_LOAD: begin
                res_acc_s = b_r;
            end
            OP_CLEAR: begin
                res_acc_s = 8'h00;
            end
            default: begin
                res_acc_s = acc_r;
            end
        endcase
    end

    // Sequencer FSM: IDLE pops into issue registers, EXEC commits the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            issue_op_r  <= OP_ADD;
            b_r         <= 8'h00;
            add_ctrl_r  <= 1'b0;
            acc_r       <= 8'h00;
            flag_c_r    <= 1'b0;
            flag_z_r    <= 1'b0;
            flag_n_r    <= 1'b0;
            flag_v_r    <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        issue_op_r <= head_s[9:8];
                        b_r        <= head_s[7:0];
                        add_ctrl_r <= (head_s[9:8] == OP_SUB);
                        state_r    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_r       <= res_acc_s;
                    flag_c_r    <= res_c_s;
                    flag_v_r    <= res_v_s;
                    flag_z_r    <= (res_acc_s == 8'h00);
                    flag_n_r    <= res_acc_s[7];
                    res_valid_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_acc_seq_8bit.sv
// -----------------------------------------------------------------------------
// Testbench for addsub_acc_seq_8bit. Models the external combinational adder,
// drives directed and random commands, and checks every res_valid pulse
// against an arithmetic reference model through a scoreboard queue.
// -----------------------------------------------------------------------------
module tb_addsub_acc_seq_8bit;

    localparam int DEPTH = 4;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] A;
    logic [7:0] B;
    logic       Add_ctrl;
    logic [7:0] SUM;
    logic       C_out;
    logic [7:0] acc;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
    logic       flag_v;
    logic       res_valid;

    int tests;
    int fails;

    addsub_acc_seq_8bit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .A(A), .B(B), .Add_ctrl(Add_ctrl),
        .SUM(SUM), .C_out(C_out),
        .acc(acc), .flag_c(flag_c), .flag_z(flag_z),
        .flag_n(flag_n), .flag_v(flag_v), .res_valid(res_valid)
    );

    // Behavioural model of the neighbouring ripple-carry adder/subtractor
    logic [8:0] sum9;
    always_comb begin
        if (Add_ctrl) sum9 = {1'b0, A} + {1'b0, ~B} + 9'd1;
        else          sum9 = {1'b0, A} + {1'b0, B};
    end
    assign SUM   = sum9[7:0];
    assign C_out = sum9[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state and scoreboard: {acc, c, z, n, v}
    int         m_acc;
    logic [11:0] sb_q[$];
    int         cycle;
    int         pulses;
    int         pulse_t[$];
    logic       saw_full;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int to_signed8(input int v);
        return (v > 127) ? v - 256 : v;
    endfunction

    // Apply one command to the reference model and queue the expected result
    task automatic model_apply(input logic [1:0] op, input logic [7:0] d);
        int dv, s, sr, res;
        bit c, v;
        dv = int'(d);
        c = 0; v = 0; res = 0;
        case (op)
            2'b00: begin
                s = m_acc + dv;
                c = (s > 255);
                sr = to_signed8(m_acc) + to_signed8(dv);
                v = (sr > 127) || (sr < -128);
                res = s % 256;
`ifdef ADDSUB_SAT_EN
                if (c) res = 255;
`endif
            end
            2'b01: begin
                s = m_acc - dv;
                c = (m_acc >= dv);
                sr = to_signed8(m_acc) - to_signed8(dv);
                v = (sr > 127) || (sr < -128);
                res = (s + 256) % 256;
`ifdef ADDSUB_SAT_EN
                if (!c) res = 0;
`endif
            end
            2'b10: res = dv;
            default: res = 0;
        endcase
        m_acc = res;
        sb_q.push_back({8'(res), c, (res == 0), (res >= 128), v});
    endtask

    // Monitor: pop and compare on every result pulse
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            pulses++;
            pulse_t.push_back(cycle);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_res_valid: got 1 expected 0 at cycle %0d", cycle);
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                chk("sb_result", {20'd0, acc, flag_c, flag_z, flag_n, flag_v}, {20'd0, e});
                chk("sb_A_tracks_acc", {24'd0, A}, {24'd0, e[11:4]});
            end
        end
    end

    // Record whether the FIFO ever reported full while a command was pending
    always @(negedge clk) begin
        if (rst_n && cmd_valid && !cmd_ready) saw_full = 1'b1;
    end

    // Present one command starting at a negedge; returns at the next negedge after acceptance
    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int g;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        g = 0;
        while (!cmd_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!cmd_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got cmd_ready=0 expected 1");
        end else begin
            model_apply(op, d);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int g;
        cmd_valid = 1'b0;
        g = 0;
        while (sb_q.size() != 0 && g < 400) begin
            @(negedge clk);
            g++;
        end
        if (sb_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_acc"}, {24'd0, acc}, 32'd0);
        chk({tag, "_A"}, {24'd0, A}, 32'd0);
        chk({tag, "_B"}, {24'd0, B}, 32'd0);
        chk({tag, "_flags"}, {27'd0, Add_ctrl, flag_c, flag_z, flag_n, flag_v}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        int p0, n;
        tests = 0; fails = 0; cycle = 0; pulses = 0; m_acc = 0; saw_full = 1'b0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        // First-command latency: accept at t0, result visible after t2
        send(2'b10, 8'h5A);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_t1_res_valid", {31'd0, res_valid}, 32'd0);
        @(negedge clk);
        chk("lat_t2_res_valid", {31'd0, res_valid}, 32'd1);
        chk("lat_t2_acc", {24'd0, acc}, 32'h5A);
        drain();

        // LOAD 0x10, ADD 0x05, SUB 0x20 back-to-back
        p0 = pulses;
        pulse_t.delete();
        send(2'b10, 8'h10);
        send(2'b00, 8'h05);
        send(2'b01, 8'h20);
        drain();
        chk("seq1_pulses", pulses - p0, 32'd3);
        if (pulse_t.size() == 3) begin
            chk("seq1_gap1", pulse_t[1] - pulse_t[0], 32'd2);
            chk("seq1_gap2", pulse_t[2] - pulse_t[1], 32'd2);
        end
`ifdef ADDSUB_SAT_EN
        chk("seq1_acc", {24'd0, acc}, 32'h00);
        chk("seq1_cn", {30'd0, flag_c, flag_n}, 32'b00);
`else
        chk("seq1_acc", {24'd0, acc}, 32'hF5);
        chk("seq1_cn", {30'd0, flag_c, flag_n}, 32'b01);
`endif

        // Signed overflow 0x7F + 0x01
        send(2'b10, 8'h7F);
        send(2'b00, 8'h01);
        drain();
        chk("ovf_acc", {24'd0, acc}, 32'h80);
        chk("ovf_cvn", {29'd0, flag_c, flag_v, flag_n}, 32'b011);

        // Unsigned carry 0xF0 + 0x20
        send(2'b10, 8'hF0);
        send(2'b00, 8'h20);
        drain();
`ifdef ADDSUB_SAT_EN
        chk("carry_acc", {24'd0, acc}, 32'hFF);
`else
        chk("carry_acc", {24'd0, acc}, 32'h10);
`endif
        chk("carry_c", {31'd0, flag_c}, 32'd1);

        // Zero result with no borrow, then CLEAR
        send(2'b10, 8'h33);
        send(2'b01, 8'h33);
        drain();
        chk("zero_acc", {24'd0, acc}, 32'h00);
        chk("zero_zc", {30'd0, flag_z, flag_c}, 32'b11);
        send(2'b11, 8'hA5);
        drain();
        chk("clear_c", {31'd0, flag_c}, 32'd0);

        // Hold cmd_valid for 10 cycles: FIFO must fill, nothing lost
        saw_full = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 10; i++) begin
            send(2'($urandom_range(0, 1)), 8'($urandom));
        end
        drain();
        chk("burst_saw_full", {31'd0, saw_full}, 32'd1);
        chk("burst_pulses", pulses - p0, 32'd10);
        chk("burst_final_acc", {24'd0, acc}, 32'(m_acc));

        // Random mix with occasional idle gaps
        p0 = pulses;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom));
            n++;
            if ($urandom_range(0, 3) == 0) begin
                cmd_valid = 1'b0;
                @(negedge clk);
            end
        end
        drain();
        chk("rand_pulses", pulses - p0, 32'(n));

        // Reset during EXEC with 3 commands queued
        p0 = pulses;
        for (int i = 0; i < 6; i++) begin
            send(2'b00, 8'($urandom_range(1, 255)));
        end
        chk("pre_rst_pulses", pulses - p0, 32'd2);
        chk("pre_rst_exec", {31'd0, res_valid}, 32'd0);
        cmd_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        m_acc = 0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        p0 = pulses;
        repeat (12) @(negedge clk);
        chk("post_rst_no_pulse", pulses - p0, 32'd0);
        check_reset_vals("post_rst");

        // Sequencer still works after reset
        send(2'b10, 8'hC3);
        send(2'b01, 8'h44);
        drain();
        chk("post_rst_acc", {24'd0, acc}, 32'h7F);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
